// File: rtl/ext_unit_pkg.sv
// Shared widths and the extension-mode encoding for the immediate extender.
package ext_unit_pkg;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

    // Decoded extension mode; lui has priority over the sign/zero choice.
    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_LUI  = 2'b10
    } ext_mode_e;

    // Collapse the two control-unit select lines into one mode.
    // luiop overrides extop, so extop never reaches the result in lui mode.
    function automatic ext_mode_e decode_mode(input logic extop, input logic luiop);
        ext_mode_e mode;
        if (luiop) begin
            mode = EXT_LUI;
        end else if (extop) begin
            mode = EXT_SIGN;
        end else begin
            mode = EXT_ZERO;
        end
        return mode;
    endfunction

endpackage

// File: rtl/ext_unit_chk.sv
// Simulation-only property checks for the registered ext_unit output.
module ext_unit_chk
    import ext_unit_pkg::*;
(
    input logic              clk,
    input logic              reset,
    input logic              luiop,
    input logic [WORD_W-1:0] ex32
);

    // A lui result always has an empty lower half one cycle later.
    a_lui_low_zero: assert property (@(posedge clk) disable iff (reset)
        luiop |=> (ex32[15:0] == 16'h0000));

    // Without lui the upper half is a pure zero or sign fill.
    a_upper_fill: assert property (@(posedge clk) disable iff (reset)
        !luiop |=> ((ex32[31:16] == 16'hFFFF) || (ex32[31:16] == 16'h0000)));

endmodule

// File: rtl/ext_unit_core.sv
// Purely combinational immediate extension: zero, sign or upper-half placement.
module ext_unit_core
    import ext_unit_pkg::*;
(
    input  logic [IMM_W-1:0]  imm16,
    input  logic              extop,
    input  logic              luiop,
    output logic [WORD_W-1:0] ex_d
);

    ext_mode_e mode_s;

    assign mode_s = decode_mode(extop, luiop);

    // Build the 32-bit operand for the selected mode.
    always_comb begin
        ex_d = 32'h0000_0000;
        case (mode_s)
            EXT_LUI:  ex_d = {imm16, 16'h0000};
            EXT_SIGN: ex_d = {{16{imm16[15]}}, imm16};
            EXT_ZERO: ex_d = {16'h0000, imm16};
            default:  ex_d = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/ext_unit.sv
// Immediate extender top: combinational core plus an optional output register.
module ext_unit
    import ext_unit_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IMM_W-1:0]  imm16,
    input  logic              extop,
    input  logic              luiop,
    output logic [WORD_W-1:0] ex32
);

    logic [WORD_W-1:0] ex_d;

    ext_unit_core u_core (
        .imm16 (imm16),
        .extop (extop),
        .luiop (luiop),
        .ex_d  (ex_d)
    );

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [WORD_W-1:0] ex32_q;

            // Output register: cleared on reset, otherwise loads a fresh result every cycle.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ex32_q <= 32'h0000_0000;
                end else begin
                    ex32_q <= ex_d;
                end
            end

            assign ex32 = ex32_q;
        end else begin : g_comb
            assign ex32 = ex_d;
        end
    endgenerate

endmodule

// File: tb/tb_ext_unit.sv
// Directed bench for ext_unit with the registered output (OUT_REG=1).
module tb_ext_unit;

    logic        clk;
    logic        reset;
    logic [15:0] imm16;
    logic        extop;
    logic        luiop;
    logic [31:0] ex32;

    int checks   = 0;
    int failures = 0;

    ext_unit #(.OUT_REG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .imm16 (imm16),
        .extop (extop),
        .luiop (luiop),
        .ex32  (ex32)
    );

    ext_unit_chk u_chk (
        .clk   (clk),
        .reset (reset),
        .luiop (luiop),
        .ex32  (ex32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] expected);
        checks++;
        assert (ex32 === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, ex32, expected);
        end
    endtask

    // Drive one set of inputs, let one rising edge pass, then compare.
    task automatic step(input logic rst, input logic [15:0] imm, input logic ext,
                        input logic lui, input string tag, input logic [31:0] expected);
        reset = rst;
        imm16 = imm;
        extop = ext;
        luiop = lui;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    initial begin
        reset = 1'b1;
        imm16 = 16'hFFFF;
        extop = 1'b1;
        luiop = 1'b0;

        // Reset held for two edges with live inputs.
        @(posedge clk);
        #1;
        check("reset_edge1", 32'h0000_0000);
        @(posedge clk);
        #1;
        check("reset_edge2", 32'h0000_0000);

        step(1'b0, 16'h8001, 1'b0, 1'b0, "zero_ext_8001",  32'h0000_8001);
        step(1'b0, 16'h8001, 1'b1, 1'b0, "sign_ext_8001",  32'hFFFF_8001);
        step(1'b0, 16'h7FFF, 1'b1, 1'b0, "sign_ext_7fff",  32'h0000_7FFF);
        step(1'b0, 16'h1234, 1'b1, 1'b1, "lui_ext1",       32'h1234_0000);
        step(1'b0, 16'h1234, 1'b0, 1'b1, "lui_ext0",       32'h1234_0000);
        step(1'b0, 16'hFFFF, 1'b0, 1'b1, "lui_ffff",       32'hFFFF_0000);
        step(1'b0, 16'hFFFF, 1'b0, 1'b0, "zero_ext_ffff",  32'h0000_FFFF);

        // Back-to-back change with no bubble.
        step(1'b0, 16'hFFFF, 1'b1, 1'b0, "b2b_first",      32'hFFFF_FFFF);
        step(1'b0, 16'h0000, 1'b0, 1'b0, "b2b_second",     32'h0000_0000);

        // Latency: a new input is not visible before the next edge.
        imm16 = 16'h8000;
        extop = 1'b1;
        #2;
        check("latency_hold", 32'h0000_0000);
        @(posedge clk);
        #1;
        check("latency_update", 32'hFFFF_8000);

        // Reset in the middle of a stream.
        step(1'b0, 16'hABCD, 1'b1, 1'b0, "stream_pre",     32'hFFFF_ABCD);
        step(1'b1, 16'hABCD, 1'b1, 1'b0, "stream_reset",   32'h0000_0000);
        step(1'b0, 16'hABCD, 1'b1, 1'b0, "stream_post",    32'hFFFF_ABCD);
        step(1'b0, 16'h0001, 1'b1, 1'b0, "sign_ext_0001",  32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ext_unit.md
# ext_unit

Immediate extender for the MIPS32 single-cycle/pipelined datapath. Takes the 16-bit instruction immediate and produces a 32-bit operand by zero-extension, sign-extension, or load-upper-immediate placement, under control-unit select lines. It sits between the instruction decode field `imm16` and the ALU B-operand mux. The result is registered on the datapath clock.

## Interface

Parameters:
- `OUT_REG`, default 1. 1 = registered output (1-cycle latency); 0 = purely combinational output (clk/reset ignored).

Ports (name, direction, width, meaning):
- `clk`, in, 1: datapath clock, rising-edge active. One clock domain.
- `reset`, in, 1: synchronous, active-high reset.
- `imm16`, in, 16: instruction immediate field [15:0].
- `extop`, in, 1: 0 = zero-extend, 1 = sign-extend.
- `luiop`, in, 1: 1 = place `imm16` in the upper half (lui); overrides `extop`.
- `ex32`, out, 32: extended immediate.

## Operation

Combinational function f(imm16, extop, luiop), evaluated in this priority order:
- `luiop`=1: f = {imm16, 16'h0000}. `extop` is don't-care.
- `luiop`=0, `extop`=1: f = {{16{imm16[15]}}, imm16}.
- `luiop`=0, `extop`=0: f = {16'h0000, imm16}.
- No X propagation from an unused select: when `luiop`=1, `extop` does not affect `ex32`.
- The output is always a full 32-bit value. No other encodings or modes exist.

## Timing

- `OUT_REG`=1:
  - At every rising `clk` with `reset`=1, the output register is loaded with 32'h0000_0000.
  - Otherwise it is loaded with f(inputs sampled at that edge).
  - `ex32` equals the registered value, so latency is exactly 1 cycle with throughput 1 per cycle.
  - There is no enable or stall, and the register updates every cycle.
- Reset value: `ex32` = 0 starting from the first edge where `reset` is sampled high. Before the first edge the value is undefined.
- Reset mid-operation: inputs on a reset edge are discarded. The first valid result appears one cycle after the first edge with `reset`=0.
- Simultaneous `luiop`=1 and `extop`=1: the lui result wins, as specified in Operation.
- `OUT_REG`=0: `ex32` = f(inputs) combinationally with zero latency. Reset has no effect.

## Structure

- No shared package is required. Optionally, a shared `mips_pkg` holds the width constants `IMM_W`=16 and `WORD_W`=32.
- Natural split:
  - Sub-module `ext_core`: purely combinational f.
  - `ext_unit` top: wraps `ext_core` with a generate-selected output register.
- Include simulation-only assertions:
  - `ex32[15:0]`==0 on the cycle after `luiop`=1.
  - Upper half is all ones or all zeros when `luiop`=0.

## Test plan

- Reset: hold `reset`=1 for 2 edges with `imm16`=16'hFFFF, `extop`=1 -> `ex32`=32'h0000_0000 throughout.
- Zero-extend: `imm16`=16'h8001, `extop`=0, `luiop`=0 -> `ex32`=32'h0000_8001 one cycle later.
- Sign-extend negative/positive:
  - `imm16`=16'h8001, `extop`=1 -> 32'hFFFF_8001.
  - `imm16`=16'h7FFF, `extop`=1 -> 32'h0000_7FFF.
- Lui priority: `imm16`=16'h1234 with `luiop`=1 and `extop`=1, then with `extop`=0 -> 32'h1234_0000 in both cases.
- Back-to-back change: drive 16'hFFFF (`extop`=1), then 16'h0000 (`extop`=0) on consecutive cycles -> 32'hFFFF_FFFF followed by 32'h0000_0000, with no bubble.
- Reset mid-stream: `imm16`=16'hABCD, `extop`=1 streaming; assert `reset` for 1 edge -> that cycle yields 32'h0000_0000, and the next cycle yields 32'hFFFF_ABCD.
